// File: rtl/fnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fnn_pkg
// Description : Shared sizing constants and feeder state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fnn_pkg;

    localparam int c_indata_width = 16;
    localparam int c_no_inputs    = 784;
    localparam int c_addr_width   = 10;

    typedef logic [1:0] feeder_state_t;

    localparam feeder_state_t c_st_fill      = 2'd0;
    localparam feeder_state_t c_st_arm       = 2'd1;
    localparam feeder_state_t c_st_stream    = 2'd2;
    localparam feeder_state_t c_st_wait_done = 2'd3;

endpackage
`default_nettype wire

// File: rtl/image_buffer_ram.sv
`default_nettype none
// ============================================================================
// Module      : image_buffer_ram
// Description : Single-port frame buffer, synchronous write, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module image_buffer_ram
    import fnn_pkg::*;
#(
    parameter int DATA_WIDTH = c_indata_width,
    parameter int ADDR_WIDTH = c_addr_width
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    // No reset on the array or read register so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/image_feeder.sv
`default_nettype none
// ============================================================================
// Module      : image_feeder
// Description : Buffers one frame from the pooling stage, then streams it
//               to the FNN one pixel per cycle once the FNN grants.
// Revision    : 1.0 - initial release
// ============================================================================
module image_feeder
    import fnn_pkg::*;
#(
    parameter int INDATA_WIDTH = c_indata_width,
    parameter int NO_INPUTS    = c_no_inputs,
    parameter int ADDR_WIDTH   = c_addr_width
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INDATA_WIDTH-1:0] pix_in,
    input  logic                    pix_valid,
    input  logic                    pix_last,
    output logic                    pix_ready,
    output logic                    start_FNN,
    output logic                    ready_in,
    input  logic                    FNN_ready_to_accept,
    output logic [INDATA_WIDTH-1:0] input_image,
    input  logic                    finish_FNN,
    output logic                    frame_err,
    output logic                    busy
);

    localparam int                     c_cnt_width = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0]  c_wr_last   = ADDR_WIDTH'(NO_INPUTS - 1);
    localparam logic [c_cnt_width-1:0] c_rd_last   = c_cnt_width'(NO_INPUTS - 1);
    localparam logic [c_cnt_width-1:0] c_rd_end    = c_cnt_width'(NO_INPUTS);

    feeder_state_t            r_state;
    feeder_state_t            w_state_next;
    logic [ADDR_WIDTH-1:0]    r_wr_cnt;
    logic [c_cnt_width-1:0]   r_rd_cnt;
    logic                     r_rd_valid;
    logic                     r_frame_err;
    logic                     w_hs;
    logic                     w_wr_last;
    logic                     w_early_last;
    logic                     w_missing_last;
    logic                     w_rd_en;
    logic [ADDR_WIDTH-1:0]    w_ram_addr;
    logic [INDATA_WIDTH-1:0]  w_ram_q;

    assign w_hs           = (r_state == c_st_fill) && pix_valid;
    assign w_wr_last      = (r_wr_cnt == c_wr_last);
    assign w_early_last   = w_hs && pix_last && !w_wr_last;
    assign w_missing_last = w_hs && !pix_last && w_wr_last;

    // The grant cycle issues address 0; STREAM keeps reading until every pixel is requested.
    assign w_rd_en = ((r_state == c_st_arm) && FNN_ready_to_accept) ||
                     ((r_state == c_st_stream) && (r_rd_cnt < c_rd_end));

    assign w_ram_addr = (r_state == c_st_fill) ? r_wr_cnt : r_rd_cnt[ADDR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_fill;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_fill: begin
                if (w_hs && w_wr_last) begin
                    w_state_next = c_st_arm;
                end
            end
            c_st_arm: begin
                if (FNN_ready_to_accept) begin
                    w_state_next = (NO_INPUTS == 1) ? c_st_wait_done : c_st_stream;
                end
            end
            c_st_stream: begin
                if (r_rd_cnt == c_rd_last) begin
                    w_state_next = c_st_wait_done;
                end
            end
            c_st_wait_done: begin
                if (finish_FNN) begin
                    w_state_next = c_st_fill;
                end
            end
            default: w_state_next = c_st_fill;
        endcase
    end

    always_comb begin
        pix_ready = 1'b0;
        start_FNN = 1'b0;
        ready_in  = 1'b0;
        busy      = 1'b1;
        case (r_state)
            c_st_fill: begin
                pix_ready = 1'b1;
                busy      = 1'b0;
            end
            c_st_arm: begin
                start_FNN = 1'b1;
                ready_in  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_rd_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rd_valid  <= w_rd_en;
            r_frame_err <= w_early_last || w_missing_last;
            if (r_state == c_st_fill) begin
                r_rd_cnt <= '0;
                // Completing or aborting a frame both restart the write pointer.
                if (w_hs) begin
                    r_wr_cnt <= (w_wr_last || pix_last) ? '0 : r_wr_cnt + 1'b1;
                end
            end else begin
                r_wr_cnt <= '0;
                if (w_rd_en) begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                end
            end
        end
    end

    // Stale read-register contents are masked so the FNN sees zero outside a burst.
    assign input_image = r_rd_valid ? w_ram_q : '0;
    assign frame_err   = r_frame_err;

    image_buffer_ram #(
        .DATA_WIDTH (INDATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_buffer (
        .clk     (clk),
        .i_we    (w_hs),
        .i_re    (w_rd_en),
        .i_addr  (w_ram_addr),
        .i_wdata (pix_in),
        .o_rdata (w_ram_q)
    );

endmodule
`default_nettype wire

// File: tb/tb_image_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_image_feeder
// Description : Directed self-checking bench for image_feeder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_image_feeder;

    localparam int c_w = 16;
    localparam int c_n = 784;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [c_w-1:0] pix_in = '0;
    logic           pix_valid = 1'b0;
    logic           pix_last = 1'b0;
    logic           pix_ready;
    logic           start_FNN;
    logic           ready_in;
    logic           FNN_ready_to_accept = 1'b0;
    logic [c_w-1:0] input_image;
    logic           finish_FNN = 1'b0;
    logic           frame_err;
    logic           busy;

    int n_tests = 0;
    int n_fail  = 0;

    image_feeder #(
        .INDATA_WIDTH (c_w),
        .NO_INPUTS    (c_n),
        .ADDR_WIDTH   (10)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .pix_in              (pix_in),
        .pix_valid           (pix_valid),
        .pix_last            (pix_last),
        .pix_ready           (pix_ready),
        .start_FNN           (start_FNN),
        .ready_in            (ready_in),
        .FNN_ready_to_accept (FNN_ready_to_accept),
        .input_image         (input_image),
        .finish_FNN          (finish_FNN),
        .frame_err           (frame_err),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feeds pixels first..last with value off+i; last_at < 0 means no pix_last.
    task automatic feed(input int first, input int last, input int last_at,
                        input bit gaps, input int off);
        int bad = 0;
        for (int i = first; i <= last; i++) begin
            int g = 0;
            while (gaps && ($urandom_range(0, 1) == 0) && (g < 8)) begin
                pix_valid = 1'b0;
                tick();
                if (pix_ready !== 1'b1) bad++;
                g++;
            end
            pix_valid = 1'b1;
            pix_in    = c_w'(off + i);
            pix_last  = (i == last_at);
            if (pix_ready !== 1'b1) bad++;
            tick();
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL feed_ready: %0d cycles with pix_ready low, required 0", bad);
        end
    endtask

    // Entered in the first ARM cycle; exercises stray finish, grant, burst and WAIT_DONE.
    task automatic stream_check(input int off, input int reset_at, input bit garbage,
                                input bit exp_err, input string tag);
        int bad_data = 0;
        int first_bad = -1;
        int bad_ready = 0;
        n_tests++;
        if ({start_FNN, ready_in, pix_ready, busy} !== 4'b1101) begin
            n_fail++;
            $display("FAIL %s_arm_flags: start/ready_in/pix_ready/busy=%b, required 1101",
                     tag, {start_FNN, ready_in, pix_ready, busy});
        end
        n_tests++;
        if ((input_image !== '0) || (frame_err !== exp_err)) begin
            n_fail++;
            $display("FAIL %s_arm_out: input_image=%0h frame_err=%b, required 0 and %b",
                     tag, input_image, frame_err, exp_err);
        end
        pix_valid  = garbage;
        pix_in     = 16'hDEAD;
        finish_FNN = 1'b1;
        tick();
        finish_FNN = 1'b0;
        tick();
        n_tests++;
        if ((start_FNN !== 1'b1) || (input_image !== '0) || (frame_err !== 1'b0)) begin
            n_fail++;
            $display("FAIL %s_arm_hold: start_FNN=%b input_image=%0h frame_err=%b, required 1 0 0",
                     tag, start_FNN, input_image, frame_err);
        end
        FNN_ready_to_accept = 1'b1;
        tick();
        FNN_ready_to_accept = 1'b0;
        for (int k = 0; k < c_n; k++) begin
            if (input_image !== c_w'(off + k)) begin
                bad_data++;
                if (first_bad < 0) first_bad = k;
            end
            if ((pix_ready !== 1'b0) || (start_FNN !== 1'b0)) bad_ready++;
            if (k == reset_at) begin
                pix_valid = 1'b0;
                rst = 1'b1;
                tick();
                rst = 1'b0;
                n_tests++;
                if ((bad_data != 0) || (bad_ready != 0)) begin
                    n_fail++;
                    $display("FAIL %s_partial_stream: %0d bad pixels (first %0d), %0d flag errors, required 0",
                             tag, bad_data, first_bad, bad_ready);
                end
                n_tests++;
                if ({input_image, start_FNN, ready_in, pix_ready, busy, frame_err} !==
                    {16'h0000, 5'b00100}) begin
                    n_fail++;
                    $display("FAIL %s_reset_stream: img=%0h start=%b rdy_in=%b pix_ready=%b busy=%b err=%b, required 0 0 0 1 0 0",
                             tag, input_image, start_FNN, ready_in, pix_ready, busy, frame_err);
                end
                return;
            end
            tick();
        end
        n_tests++;
        if ((bad_data != 0) || (bad_ready != 0)) begin
            n_fail++;
            $display("FAIL %s_stream_data: %0d bad pixels (first %0d), %0d flag errors, required 0",
                     tag, bad_data, first_bad, bad_ready);
        end
        for (int j = 0; j < 3; j++) begin
            n_tests++;
            if ({input_image, start_FNN, ready_in, pix_ready, busy} !== {16'h0000, 4'b0001}) begin
                n_fail++;
                $display("FAIL %s_wait_done_%0d: img=%0h start=%b rdy_in=%b pix_ready=%b busy=%b, required 0 0 0 0 1",
                         tag, j, input_image, start_FNN, ready_in, pix_ready, busy);
            end
            tick();
        end
        pix_valid  = 1'b0;
        finish_FNN = 1'b1;
        tick();
        finish_FNN = 1'b0;
        n_tests++;
        if ({pix_ready, busy, start_FNN} !== 3'b100) begin
            n_fail++;
            $display("FAIL %s_finish: pix_ready/busy/start=%b, required 100",
                     tag, {pix_ready, busy, start_FNN});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({pix_ready, start_FNN, ready_in, frame_err, busy} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_flags: ready/start/rdy_in/err/busy=%b, required 10000",
                     {pix_ready, start_FNN, ready_in, frame_err, busy});
        end
        n_tests++;
        if (input_image !== '0) begin
            n_fail++;
            $display("FAIL reset_image: got %0h, required 0", input_image);
        end
        rst = 1'b0;
    endtask

    task automatic test_normal_frame();
        feed(0, c_n - 1, c_n - 1, 1'b0, 0);
        stream_check(0, -1, 1'b0, 1'b0, "normal");
    endtask

    task automatic test_early_last();
        feed(0, 99, 99, 1'b0, 500);
        n_tests++;
        if ({frame_err, pix_ready, busy} !== 3'b110) begin
            n_fail++;
            $display("FAIL early_err: err/pix_ready/busy=%b, required 110", {frame_err, pix_ready, busy});
        end
        tick();
        n_tests++;
        if ((frame_err !== 1'b0) || (dut.r_wr_cnt !== '0)) begin
            n_fail++;
            $display("FAIL early_clear: frame_err=%b wr_cnt=%0d, required 0 and 0", frame_err, dut.r_wr_cnt);
        end
        feed(0, c_n - 1, c_n - 1, 1'b0, 1000);
        stream_check(1000, -1, 1'b0, 1'b0, "after_early");
    endtask

    task automatic test_missing_last();
        feed(0, c_n - 1, -1, 1'b0, 2000);
        stream_check(2000, -1, 1'b0, 1'b1, "missing_last");
    endtask

    task automatic test_backpressure();
        feed(0, c_n - 1, c_n - 1, 1'b1, 3000);
        stream_check(3000, -1, 1'b1, 1'b0, "gaps");
    endtask

    task automatic test_reset_mid_stream();
        feed(0, c_n - 1, c_n - 1, 1'b0, 4000);
        stream_check(4000, 400, 1'b0, 1'b0, "mid_reset");
        feed(0, c_n - 1, c_n - 1, 1'b0, 5000);
        stream_check(5000, -1, 1'b0, 1'b0, "post_reset");
    endtask

    task automatic test_stray_finish();
        feed(0, 4, -1, 1'b0, 6000);
        finish_FNN = 1'b1;
        tick();
        finish_FNN = 1'b0;
        n_tests++;
        if ((pix_ready !== 1'b1) || (busy !== 1'b0) || (dut.r_wr_cnt !== 10'd5)) begin
            n_fail++;
            $display("FAIL fill_stray_finish: pix_ready=%b busy=%b wr_cnt=%0d, required 1 0 5",
                     pix_ready, busy, dut.r_wr_cnt);
        end
        feed(5, c_n - 1, c_n - 1, 1'b0, 6000);
        stream_check(6000, -1, 1'b0, 1'b0, "stray_finish");
    endtask

    initial begin
        test_reset();
        test_normal_frame();
        test_early_last();
        test_missing_last();
        test_backpressure();
        test_reset_mid_stream();
        test_stray_finish();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/image_feeder.md
IMAGE_FEEDER -- requirements
Module: image_feeder

Interface
REQ-001 SHALL have parameter INDATA_WIDTH, default 16, meaning pixel width in bits.
REQ-002 SHALL have parameter NO_INPUTS, default 784, meaning pixels per frame.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, meaning buffer address width; it SHALL satisfy 2**ADDR_WIDTH >= NO_INPUTS.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is posedge clk.
REQ-005 SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-006 SHALL have port pix_in, input, INDATA_WIDTH, the upstream (maxpool) pixel.
REQ-007 SHALL have port pix_valid, input, 1, meaning pix_in is valid.
REQ-008 SHALL have port pix_last, input, 1, marking the last pixel of a frame.
REQ-009 SHALL have port pix_ready, output, 1, meaning the feeder accepts a pixel.
REQ-010 SHALL have port start_FNN, output, 1, the request for the FNN to begin a frame.
REQ-011 SHALL have port ready_in, output, 1, meaning a full frame is buffered.
REQ-012 SHALL have port FNN_ready_to_accept, input, 1, the FNN streaming grant.
REQ-013 SHALL have port input_image, output, INDATA_WIDTH, the pixel presented to the FNN.
REQ-014 SHALL have port finish_FNN, input, 1, FNN classification complete.
REQ-015 SHALL have port frame_err, output, 1, a one-cycle pulse on a framing error.
REQ-016 SHALL have port busy, output, 1, high in every state except FILL.

Function
REQ-017 SHALL implement the states FILL, ARM, STREAM and WAIT_DONE; the reset state is FILL.
REQ-018 In FILL, pix_ready SHALL be 1; each cycle with pix_valid&pix_ready SHALL write pix_in to buf[wr_cnt] and increment wr_cnt.
REQ-019 A handshake with pix_last=1 and wr_cnt<NO_INPUTS-1 (early last) SHALL pulse frame_err, discard the frame, zero wr_cnt and stay in FILL.
REQ-020 The handshake at wr_cnt=NO_INPUTS-1 SHALL complete the frame whatever the value of pix_last; if pix_last=0 there, frame_err SHALL pulse and the frame SHALL still be kept.
REQ-021 On frame completion the next state SHALL be ARM, and pix_ready SHALL be 0 from the next cycle.
REQ-022 In ARM, start_FNN and ready_in SHALL be 1 and input_image SHALL be 0; on the first cycle T with FNN_ready_to_accept=1, the block SHALL issue read address 0 and enter STREAM.
REQ-023 The buffer read SHALL have one-cycle registered latency: input_image SHALL equal buf[k] in cycle T+1+k, for k = 0..NO_INPUTS-1, as one pixel per cycle with no stalls.
REQ-024 Once streaming starts, deassertion of FNN_ready_to_accept SHALL be ignored.
REQ-025 In cycle T+1+NO_INPUTS and afterwards, input_image SHALL be 0, and the state SHALL be WAIT_DONE.
REQ-026 In WAIT_DONE, start_FNN and ready_in SHALL be 0; finish_FNN=1 SHALL return the block to FILL with wr_cnt=0.
REQ-027 A finish_FNN asserted outside WAIT_DONE SHALL be ignored.
REQ-028 Buffer contents SHALL be overwritten only in FILL, and reads SHALL occur only in STREAM, so a single-port memory suffices.
REQ-029 Counters SHALL never wrap: wr_cnt and rd_cnt saturate their use at NO_INPUTS.

Reset
REQ-030 rst=1 at any posedge SHALL force state=FILL, wr_cnt=0, rd_cnt=0, pix_ready=1 (from the next cycle), start_FNN=0, ready_in=0, input_image=0, frame_err=0 and busy=0.
REQ-031 rst SHALL take priority over all other inputs, including in mid-FILL and mid-STREAM; any partial frame is discarded.
REQ-032 Buffer memory contents SHALL NOT be cleared by reset.

Structure
REQ-033 The shared package fnn_pkg SHALL hold INDATA_WIDTH, NO_INPUTS, ADDR_WIDTH and the feeder state encoding.
REQ-034 The block SHALL instantiate one sub-module, image_buffer_ram: single-port, depth 2**ADDR_WIDTH, width INDATA_WIDTH, with synchronous write and a registered read.

Verification
REQ-035 Normal frame: write pixels 0..783 with values=index and pix_last at 783, then grant accept -> ready_in=1; input_image=0,1,...,783 on consecutive cycles starting at T+1; then input_image=0.
REQ-036 Early last: pix_last on the 100th pixel -> frame_err one pulse, state stays FILL, wr_cnt=0; the next full frame streams correctly.
REQ-037 Missing last: 784 pixels with pix_last=0 -> frame_err pulse on the 784th handshake, ARM entered, data streams intact.
REQ-038 Backpressure/gaps: random pix_valid gaps (50%) -> identical buffered frame; pix_ready=0 throughout ARM, STREAM and WAIT_DONE.
REQ-039 Reset mid-STREAM at k=400 -> next cycle input_image=0, start_FNN=0, state FILL; a later full frame streams from pixel 0.
REQ-040 Stray finish_FNN during FILL and ARM -> no state change; finish_FNN in WAIT_DONE -> FILL, pix_ready=1.
